// File: rtl/lane_reorder_ctrl.sv
// Receive lane-reorder sequencer: walks physical lanes after deskew lock, builds the
// logical-to-physical map from detected lane IDs, and publishes it atomically on success.
module lane_reorder_ctrl #(
    parameter int N_LANES   = 20,
    parameter int NB_ID     = $clog2(N_LANES),
    parameter int NB_BUS_ID = N_LANES*NB_ID
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_enable,
    input  logic                 i_valid,
    input  logic                 i_lanes_deskewed,
    input  logic                 i_restart,
    input  logic [NB_BUS_ID-1:0] i_lane_id,
    output logic [NB_BUS_ID-1:0] o_lane_select,
    output logic                 o_reorder_done,
    output logic                 o_reorder_error,
    output logic [2:0]           o_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_BUILD  = 3'd2,
        ST_LOCKED = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam logic [NB_ID-1:0] LAST_LANE  = NB_ID'(N_LANES-1);
    localparam logic [NB_ID:0]   LANE_LIMIT = (NB_ID+1)'(N_LANES);

    state_t               state;
    state_t               next_state;
    logic [NB_ID-1:0]     cnt;
    logic [N_LANES-1:0]   seen;
    logic [NB_BUS_ID-1:0] shadow;
    logic [NB_BUS_ID-1:0] shadow_next;
    logic [NB_ID-1:0]     cur_id;
    logic                 id_bad;
    logic                 build_qual;
    logic                 step_ok;
    logic                 last_step;

    // ID reported by the physical lane currently being walked
    always_comb begin
        cur_id = '0;
        for (int unsigned p = 0; p < N_LANES; p++) begin
            if (cnt == NB_ID'(p)) begin
                cur_id = i_lane_id[p*NB_ID +: NB_ID];
            end
        end
    end

    always_comb begin
        id_bad = ({1'b0, cur_id} >= LANE_LIMIT);
        for (int unsigned k = 0; k < N_LANES; k++) begin
            if ((cur_id == NB_ID'(k)) && seen[k]) begin
                id_bad = 1'b1;
            end
        end
    end

    // A BUILD step only counts when no higher-priority exit is taken in the same cycle
    assign build_qual = (state == ST_BUILD) && i_enable && !i_restart &&
                        i_lanes_deskewed && i_valid;
    assign step_ok    = build_qual && !id_bad;
    assign last_step  = step_ok && (cnt == LAST_LANE);

    always_comb begin
        shadow_next = shadow;
        for (int unsigned k = 0; k < N_LANES; k++) begin
            if (cur_id == NB_ID'(k)) begin
                shadow_next[k*NB_ID +: NB_ID] = cnt;
            end
        end
    end

    always_comb begin
        next_state = state;
        if (!i_enable) begin
            next_state = ST_IDLE;
        end else if (i_restart) begin
            next_state = ST_WAIT;
        end else begin
            case (state)
                ST_IDLE: next_state = ST_WAIT;
                ST_WAIT: begin
                    if (i_lanes_deskewed) next_state = ST_BUILD;
                end
                ST_BUILD: begin
                    if (!i_lanes_deskewed) begin
                        next_state = ST_WAIT;
                    end else if (i_valid) begin
                        if (id_bad) begin
                            next_state = ST_ERROR;
                        end else if (cnt == LAST_LANE) begin
                            next_state = ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (!i_lanes_deskewed) next_state = ST_WAIT;
                end
                ST_ERROR: begin
                    if (!i_lanes_deskewed) next_state = ST_WAIT;
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt    <= '0;
            seen   <= '0;
            shadow <= '0;
        end else if (state == ST_WAIT) begin
            cnt  <= '0;
            seen <= '0;
        end else if (step_ok) begin
            shadow <= shadow_next;
            cnt    <= cnt + NB_ID'(1);
            for (int unsigned k = 0; k < N_LANES; k++) begin
                if (cur_id == NB_ID'(k)) begin
                    seen[k] <= 1'b1;
                end
            end
        end else if (build_qual) begin
            shadow <= '0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int unsigned k = 0; k < N_LANES; k++) begin
                o_lane_select[k*NB_ID +: NB_ID] <= NB_ID'(k);
            end
        end else if (last_step) begin
            o_lane_select <= shadow_next;
        end
    end

    assign o_state         = state;
    assign o_reorder_done  = (state == ST_LOCKED);
    assign o_reorder_error = (state == ST_ERROR);

endmodule

// File: tb/tb_lane_reorder_ctrl.sv
// Scoreboard bench for lane_reorder_ctrl: stimulus pushes expected done/error events,
// a monitor pops and compares them whenever done or error rises.
module tb_lane_reorder_ctrl;
    localparam int N   = 20;
    localparam int W   = 5;
    localparam int BUS = N*W;

    typedef int id_arr_t [N];
    typedef struct {
        bit             is_err;
        logic [BUS-1:0] map;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic           valid = 1'b0;
    logic           deskewed = 1'b0;
    logic           restart = 1'b0;
    logic [BUS-1:0] lane_id = '0;
    logic [BUS-1:0] lane_select;
    logic           done;
    logic           err;
    logic [2:0]     state;

    int             errors = 0;
    int             checks = 0;
    exp_t           sbq[$];
    logic [BUS-1:0] cur_map;
    logic [BUS-1:0] ident;
    logic           prev_done = 1'b0;
    logic           prev_err = 1'b0;

    lane_reorder_ctrl #(.N_LANES(N), .NB_ID(W), .NB_BUS_ID(BUS)) dut (
        .i_clock          (clk),
        .i_reset_n        (rst_n),
        .i_enable         (enable),
        .i_valid          (valid),
        .i_lanes_deskewed (deskewed),
        .i_restart        (restart),
        .i_lane_id        (lane_id),
        .o_lane_select    (lane_select),
        .o_reorder_done   (done),
        .o_reorder_error  (err),
        .o_state          (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [BUS-1:0] act, input logic [BUS-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [BUS-1:0] pack(input id_arr_t a);
        logic [BUS-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*W +: W] = W'(a[k]);
        return r;
    endfunction

    // Reference: walk lanes in order; first out-of-range or repeated ID is the error step,
    // otherwise the map is the inverse permutation (logical k -> physical lane).
    function automatic void model(input id_arr_t ids, output bit is_err, output int step,
                                  output logic [BUS-1:0] map);
        bit seen[N];
        id_arr_t inv;
        is_err = 0;
        step = N;
        map = '0;
        for (int k = 0; k < N; k++) begin
            seen[k] = 0;
            inv[k] = 0;
        end
        for (int p = 0; p < N; p++) begin
            if (ids[p] >= N || ids[p] < 0 || seen[ids[p]]) begin
                is_err = 1;
                step = p + 1;
                break;
            end
            seen[ids[p]] = 1;
            inv[ids[p]] = p;
        end
        if (!is_err) map = pack(inv);
    endfunction

    function automatic id_arr_t rand_perm();
        id_arr_t a;
        int j, t;
        for (int k = 0; k < N; k++) a[k] = k;
        for (int k = N-1; k > 0; k--) begin
            j = $urandom_range(0, k);
            t = a[k]; a[k] = a[j]; a[j] = t;
        end
        return a;
    endfunction

    task automatic check_event(input bit is_err);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got %s with nothing expected", is_err ? "error" : "done");
            return;
        end
        e = sbq.pop_front();
        chk("event_kind_is_error", is_err, e.is_err);
        chk(is_err ? "map_on_error" : "map_on_done", lane_select, e.map);
    endtask

    always @(negedge clk) begin
        if (done && !prev_done) check_event(1'b0);
        if (err && !prev_err) check_event(1'b1);
        prev_done = done;
        prev_err  = err;
    end

    // Caller must be at a negedge with the DUT in WAIT; edge 0 is the WAIT->BUILD edge.
    task automatic build(input id_arr_t ids, input int mode);
        bit             is_err;
        int             step, target, nval, exp_edges, edges;
        bit             held, v;
        logic [BUS-1:0] m;
        exp_t           e;
        model(ids, is_err, step, m);
        e.is_err = is_err;
        e.map    = is_err ? cur_map : m;
        sbq.push_back(e);
        target = is_err ? step : N;
        nval = 0; exp_edges = -1; edges = -1; held = 1;
        chk("state_before_build", state, 3'd1);
        lane_id  = pack(ids);
        deskewed = 1'b1;
        for (int k = 0; k < 400; k++) begin
            case (mode)
                0:       v = 1;
                1:       v = (k % 2 == 1);
                default: v = 1'($urandom_range(0, 1));
            endcase
            valid = v;
            if (k >= 1 && v) begin
                nval++;
                if (nval == target && exp_edges < 0) exp_edges = k + 1;
            end
            @(negedge clk);
            if (done || err) begin
                edges = k + 1;
                break;
            end
            if (lane_select !== cur_map) held = 0;
        end
        valid = 1'b0;
        chk("latency_edges", edges, exp_edges);
        chk("map_held_during_build", held, 1'b1);
        chk("state_after_build", state, is_err ? 3'd4 : 3'd3);
        if (!is_err) cur_map = m;
    endtask

    task automatic to_wait();
        deskewed = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        chk("state_wait", state, 3'd1);
        chk("done_low_in_wait", done, 1'b0);
        chk("map_held_in_wait", lane_select, cur_map);
    endtask

    task automatic restart_pulse();
        restart = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        restart = 1'b0;
        chk("state_after_restart", state, 3'd1);
        chk("error_low_after_restart", err, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        id_arr_t ids;
        int a, b;
        for (int k = 0; k < N; k++) ident[k*W +: W] = W'(k);
        cur_map = ident;

        #12;
        chk("reset_state", state, 3'd0);
        chk("reset_done", done, 1'b0);
        chk("reset_error", err, 1'b0);
        chk("reset_map_identity", lane_select, ident);
        @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        chk("idle_to_wait", state, 3'd1);

        for (int k = 0; k < N; k++) ids[k] = k;
        build(ids, 0);
        chk("identity_map", lane_select, ident);

        to_wait();
        for (int k = 0; k < N; k++) ids[k] = N - 1 - k;
        build(ids, 1);
        chk("rev_field0", lane_select[0 +: W], 5'd19);
        chk("rev_field19", lane_select[19*W +: W], 5'd0);

        to_wait();
        for (int k = 0; k < N; k++) ids[k] = k;
        ids[3] = 5; ids[5] = 3; ids[7] = 5;
        build(ids, 0);
        repeat (3) @(negedge clk);
        chk("error_sticky", err, 1'b1);
        chk("map_held_in_error", lane_select, cur_map);
        to_wait();
        build(rand_perm(), 2);

        to_wait();
        ids = rand_perm();
        ids[0] = 25;
        build(ids, 0);
        restart_pulse();
        build(rand_perm(), 1);

        to_wait();
        ids = rand_perm();
        lane_id = pack(ids);
        deskewed = 1'b1;
        valid = 1'b1;
        repeat (11) @(negedge clk);
        deskewed = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        chk("partial_state_wait", state, 3'd1);
        chk("partial_no_done", done, 1'b0);
        chk("partial_map_unchanged", lane_select, cur_map);
        build(ids, 0);

        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 1) == 1) restart_pulse();
            else to_wait();
            ids = rand_perm();
            case ($urandom_range(0, 3))
                0: ids[$urandom_range(0, N-1)] = int'($urandom_range(N, 31));
                1: begin
                    a = int'($urandom_range(0, N-1));
                    b = (a + int'($urandom_range(1, N-1))) % N;
                    ids[b] = ids[a];
                end
                default: ;
            endcase
            build(ids, int'($urandom_range(0, 2)));
        end

        to_wait();
        build(rand_perm(), 0);
        enable = 1'b0;
        @(negedge clk);
        chk("disable_state_idle", state, 3'd0);
        chk("disable_done_low", done, 1'b0);
        chk("disable_map_held", lane_select, cur_map);
        enable = 1'b1;
        deskewed = 1'b0;
        @(negedge clk);
        chk("reenable_wait", state, 3'd1);

        lane_id = pack(rand_perm());
        deskewed = 1'b1;
        valid = 1'b1;
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_state", state, 3'd0);
        chk("async_reset_done", done, 1'b0);
        chk("async_reset_error", err, 1'b0);
        chk("async_reset_map_identity", lane_select, ident);
        cur_map = ident;
        deskewed = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_wait", state, 3'd1);

        chk("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lane_reorder_ctrl.md
# lane_reorder_ctrl

Sequencing controller for the receive lane-reorder stage. After the deskew stage reports alignment, it walks the physical lanes one per qualified cycle and builds a logical-to-physical map from the per-lane detected lane IDs. It checks the IDs for duplicates and out-of-range values, and publishes the map atomically to the reorder mux. It sits between lane deskew (alignment-marker lock) and the reorder mux that feeds the PCS descrambler/decoder.

## Interface
- `N_LANES`, default 20: number of PCS lanes.
- `NB_ID`, default `$clog2(N_LANES)` (5): width of one lane ID.
- `NB_BUS_ID`, default `N_LANES*NB_ID` (100): width of a packed ID bus.
- `i_clock`, input, 1: single clock for all logic.
- `i_reset_n`, input, 1: asynchronous, active-low reset.
- `i_enable`, input, 1: block enable; when low, the FSM is forced to IDLE.
- `i_valid`, input, 1: qualifies the current cycle for a BUILD step.
- `i_lanes_deskewed`, input, 1: level signal from deskew; all lanes are aligned.
- `i_restart`, input, 1: single-cycle request to rebuild the map.
- `i_lane_id`, input, NB_BUS_ID: field p (bits `[p*NB_ID +: NB_ID]`) is the logical ID detected on physical lane p.
- `o_lane_select`, output, NB_BUS_ID: field k is the physical lane carrying logical lane k.
- `o_reorder_done`, output, 1: map is complete and published (LOCKED).
- `o_reorder_error`, output, 1: an invalid ID set was detected (ERROR).
- `o_state`, output, 3: current FSM state, for debug.

## Operation
- FSM states and encodings: IDLE=0, WAIT=1, BUILD=2, LOCKED=3, ERROR=4.
- Internal storage: shadow table (NB_BUS_ID), seen mask (N_LANES bits), and a physical-lane counter `cnt` (NB_ID bits).
- Transition priority in every state, highest first: reset > `!i_enable` → IDLE > `i_restart` → WAIT > normal transitions.
- IDLE: if `i_enable`=1, go to WAIT.
- WAIT: clear the seen mask and set `cnt`=0. If `i_lanes_deskewed`=1, go to BUILD.
- BUILD, on a cycle with `i_valid`=1:
  - Let `id = i_lane_id[cnt*NB_ID +: NB_ID]`.
  - If `id >= N_LANES` or `seen[id]`=1: go to ERROR and discard the shadow table.
  - Otherwise: set `shadow[id] <= cnt`, `seen[id] <= 1`, `cnt <= cnt+1`.
  - If the write succeeds with `cnt == N_LANES-1`: go to LOCKED and copy the complete shadow table (including this final write) into the `o_lane_select` register in the same edge.
  - With N distinct in-range IDs, completeness follows, so no separate check state is needed.
- BUILD, on a cycle with `i_valid`=0: hold all state; there is no timeout.
- BUILD, if `i_lanes_deskewed` falls: go to WAIT. A partial map is never published.
- LOCKED: `o_reorder_done`=1. If `i_lanes_deskewed` falls, go to WAIT. IDs are not re-checked while locked.
- ERROR: `o_reorder_error`=1. If `i_lanes_deskewed` falls, go to WAIT. `i_restart` also leaves ERROR.
- `o_lane_select` changes only on entry to LOCKED and on reset. It holds its last value in every other state, including IDLE, WAIT and ERROR.
- `cnt` is never compared beyond N_LANES-1 and never wraps, because BUILD exits at N_LANES-1.

## Timing
- Reset values:
  - State = IDLE, `cnt`=0, seen mask=0, shadow table=0.
  - `o_reorder_done`=0, `o_reorder_error`=0, `o_state`=0.
  - `o_lane_select` = identity map (field k = k).
- All outputs are registered. `o_reorder_done` and `o_reorder_error` are decoded from the state register.
- Latency:
  - The WAIT→BUILD transition occurs on the first edge where `i_lanes_deskewed`=1.
  - The map completes after exactly N_LANES qualified BUILD cycles.
  - `o_reorder_done` and the new `o_lane_select` appear together, the cycle after the last qualified write.
  - With `i_valid` held high, `o_reorder_done` rises N_LANES+1 cycles after `i_lanes_deskewed` is first sampled high in WAIT.
- Error latency: `o_reorder_error` rises the cycle after the offending `i_valid` cycle.
- `i_restart` in WAIT: WAIT is re-entered, so the seen mask and `cnt` are cleared again. This is harmless.
- `i_restart` and deskew loss in the same cycle: both lead to WAIT.
- Asynchronous reset mid-BUILD: all state returns to reset values immediately, and `o_lane_select` reverts to identity.

## Test plan
- Identity IDs (lane p reports p), `i_valid`=1 continuously → `o_reorder_done`=1 at cycle 21 after deskew is sampled; `o_lane_select` field k = k.
- Reversed IDs (lane p reports 19-p) with `i_valid` toggling 1,0 → done after 40 cycles; field 0 = 19, field 19 = 0; `o_lane_select` unchanged (identity) until done.
- Duplicate: lanes 3 and 7 both report ID 5 → `o_reorder_error`=1 the cycle after lane 7 is processed; `o_lane_select` holds its previous map; deskew drop then rise plus a good ID set → done.
- Out-of-range: lane 0 reports 25 → ERROR after 1 qualified cycle; `i_restart` → WAIT, then a rebuild succeeds.
- Deskew falls after 10 BUILD steps → WAIT, no done, map unchanged; re-deskew → full 20-step rebuild.
- `i_enable`=0 in LOCKED → IDLE, done=0, map held; `i_reset_n` asserted mid-BUILD → all outputs at reset values, `o_lane_select` identity.
